mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/mc_controller_if.sv | 35 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mc_controller.sv | 169 ++++++++++++++++
 tb/tb_mc_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// datapath mux selects and the bundled control-word type.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_ALU_WB_R,
        S_EXEC_I,
        S_ALU_WB_I,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        ALUB_REG     = 2'b00,
        ALUB_FOUR    = 2'b01,
        ALUB_IMM     = 2'b10,
        ALUB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        pc_src_t    pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
    } ctrl_out_t;

    // States in which the FSM stalls on mem_ready and the wait timer runs.
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit bus: opcode and memory handshake in, datapath strobes and
// mux selects out, plus the sticky fault flags.
interface mc_controller_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, bus_err
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, bus_err
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; done flags the cycle in which the
// count would reach MEM_TIMEOUT with the access still outstanding.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign done = enable && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (lw/sw/beq/j/addi/R-type) with memory-wait
// timeout and sticky illegal-opcode / bus-error flags.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus
);
    state_t    state;
    state_t    next_state;
    ctrl_out_t ctl;
    logic      illegal_op;
    logic      bus_err;
    logic      set_illegal;
    logic      set_bus_err;
    logic      in_wait;
    logic      wait_done;

    assign in_wait = is_wait_state(state);

    // Completing an access clears the count, so mem_ready beats a timeout.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait || bus.mem_ready),
        .enable (in_wait && !bus.mem_ready),
        .done   (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (set_illegal) illegal_op <= 1'b1;
            if (set_bus_err) bus_err    <= 1'b1;
        end
    end

    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    next_state = S_DECODE;
                end else if (wait_done) begin
                    next_state  = S_FAULT;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     next_state = S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_EXEC_I;
                    default: begin
                        next_state  = S_FAULT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: next_state = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (wait_done) begin
                    next_state  = S_FAULT;
                    set_bus_err = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (wait_done) begin
                    next_state  = S_FAULT;
                    set_bus_err = 1'b1;
                end
            end
            S_MEM_WB, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_EXEC_R:   next_state = S_ALU_WB_R;
            S_EXEC_I:   next_state = S_ALU_WB_I;
            S_FAULT:    next_state = S_FAULT;
            default:    next_state = S_FAULT;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = ALUB_FOUR;
                ctl.pc_write  = bus.mem_ready;
                ctl.ir_write  = bus.mem_ready;
            end
            S_DECODE:   ctl.alu_src_b = ALUB_IMM_SH2;
            S_MEM_ADDR, S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_ALU_WB_I: ctl.reg_write = 1'b1;
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.pc_write      = ctl.pc_write;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.iord          = ctl.iord;
    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.ir_write      = ctl.ir_write;
    assign bus.reg_dst       = ctl.reg_dst;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.alu_op        = ctl.alu_op;
    assign bus.illegal_op    = illegal_op;
    assign bus.bus_err       = bus_err;

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle check of mc_controller outputs against a reference table
// of expected states, with a short-timeout instance for the bus-error paths.
module tb_mc_controller;

    localparam int TO = 4;

    localparam logic [5:0] R    = 6'h00;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2b;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] J    = 6'h02;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] BAD  = 6'h3f;

    typedef enum {
        L_IDLE, L_FETCH, L_DECODE, L_MEM_ADDR, L_MEM_RD, L_MEM_WB, L_MEM_WR,
        L_EXEC_R, L_ALU_WB_R, L_EXEC_I, L_ALU_WB_I, L_BRANCH, L_JUMP, L_FAULT
    } lbl_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       bus_err;
    } out_t;

    typedef struct {
        bit       chk;
        bit       rst;
        bit       rdy;
        bit [5:0] op;
        lbl_t     st;
        bit       ill;
        bit       berr;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    out_t exp_q[$];
    vec_t vecs[$];

    mc_controller_if bus ();

    mc_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for the state the FSM should be in this cycle.
    function automatic out_t ref_out(lbl_t st, bit rdy, bit ill, bit berr);
        out_t o;
        o = '0;
        case (st)
            L_FETCH: begin
                o.mem_read = 1; o.alu_src_b = 2'b01;
                o.pc_write = rdy; o.ir_write = rdy;
            end
            L_DECODE:   o.alu_src_b = 2'b11;
            L_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            L_EXEC_I:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            L_MEM_RD:   begin o.mem_read = 1; o.iord = 1; end
            L_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
            L_MEM_WR:   begin o.mem_write = 1; o.iord = 1; end
            L_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            L_ALU_WB_R: begin o.reg_write = 1; o.reg_dst = 1; end
            L_ALU_WB_I: o.reg_write = 1;
            L_BRANCH: begin
                o.alu_src_a = 1; o.alu_op = 2'b01;
                o.pc_write_cond = 1; o.pc_source = 2'b01;
            end
            L_JUMP:     begin o.pc_write = 1; o.pc_source = 2'b10; end
            default: ;
        endcase
        o.illegal_op = ill;
        o.bus_err    = berr;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.pc_source     = bus.pc_source;
        o.iord          = bus.iord;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.reg_dst       = bus.reg_dst;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_write     = bus.reg_write;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.illegal_op    = bus.illegal_op;
        o.bus_err       = bus.bus_err;
        return o;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare at negedge.
    task automatic step(input vec_t v, input string name);
        out_t got;
        out_t exp;
        rst           = v.rst;
        bus.mem_ready = v.rdy;
        bus.opcode    = v.op;
        if (v.chk) exp_q.push_back(ref_out(v.st, v.rdy, v.ill, v.berr));
        @(negedge clk);
        if (v.chk) begin
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, got, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit r, input bit rdy, input logic [5:0] op,
                       input lbl_t st, input bit ill, input bit berr, input string tag);
        vec_t v;
        v = '{1'b1, r, rdy, op, st, ill, berr};
        step(v, $sformatf("%s_%s", tag, st.name()));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset, R-type, lw with two waits, beq, j, addi with one fetch wait,
        // sw interrupted by reset, fetch timeout, completion on the limit cycle.
        vecs.push_back('{0, 1, 1, R,    L_IDLE,     0, 0});
        vecs.push_back('{1, 1, 1, R,    L_IDLE,     0, 0});
        vecs.push_back('{1, 1, 1, R,    L_IDLE,     0, 0});
        vecs.push_back('{1, 0, 1, R,    L_IDLE,     0, 0});
        vecs.push_back('{1, 0, 1, R,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, R,    L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, R,    L_EXEC_R,   0, 0});
        vecs.push_back('{1, 0, 1, R,    L_ALU_WB_R, 0, 0});
        vecs.push_back('{1, 0, 1, LW,   L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, LW,   L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, LW,   L_MEM_ADDR, 0, 0});
        vecs.push_back('{1, 0, 0, LW,   L_MEM_RD,   0, 0});
        vecs.push_back('{1, 0, 0, LW,   L_MEM_RD,   0, 0});
        vecs.push_back('{1, 0, 1, LW,   L_MEM_RD,   0, 0});
        vecs.push_back('{1, 0, 1, LW,   L_MEM_WB,   0, 0});
        vecs.push_back('{1, 0, 1, BEQ,  L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, BEQ,  L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, BEQ,  L_BRANCH,   0, 0});
        vecs.push_back('{1, 0, 1, J,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, J,    L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, J,    L_JUMP,     0, 0});
        vecs.push_back('{1, 0, 0, ADDI, L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, ADDI, L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, ADDI, L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, ADDI, L_EXEC_I,   0, 0});
        vecs.push_back('{1, 0, 1, ADDI, L_ALU_WB_I, 0, 0});
        vecs.push_back('{1, 0, 1, SW,   L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, SW,   L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, SW,   L_MEM_ADDR, 0, 0});
        vecs.push_back('{1, 0, 0, SW,   L_MEM_WR,   0, 0});
        vecs.push_back('{1, 1, 0, SW,   L_MEM_WR,   0, 0});
        vecs.push_back('{1, 0, 0, SW,   L_IDLE,     0, 0});
        vecs.push_back('{1, 0, 0, R,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, R,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, R,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, R,    L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, R,    L_FAULT,    0, 1});
        vecs.push_back('{1, 0, 1, R,    L_FAULT,    0, 1});
        vecs.push_back('{1, 1, 1, R,    L_FAULT,    0, 1});
        vecs.push_back('{1, 0, 0, R,    L_IDLE,     0, 0});
        vecs.push_back('{1, 0, 0, BAD,  L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, BAD,  L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 0, BAD,  L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, BAD,  L_FETCH,    0, 0});
        vecs.push_back('{1, 0, 1, BAD,  L_DECODE,   0, 0});
        vecs.push_back('{1, 0, 1, BAD,  L_FAULT,    1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("row%0d_%s", i, vecs[i].st.name()));
        end

        // Illegal-opcode fault must hold with every strobe low for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            run(1'b0, 1'(($urandom) & 1), 6'($urandom), L_FAULT, 1'b1, 1'b0, $sformatf("hold%0d", i));
        end
        run(1'b1, 1'b1, R, L_FAULT, 1'b1, 1'b0, "rst_in_fault");
        run(1'b0, 1'b1, R, L_IDLE,  1'b0, 1'b0, "after_rst");

        // lw whose data phase never completes: bus error out of MEM_RD.
        run(1'b0, 1'b1, LW, L_FETCH,    1'b0, 1'b0, "rdto");
        run(1'b0, 1'b1, LW, L_DECODE,   1'b0, 1'b0, "rdto");
        run(1'b0, 1'b1, LW, L_MEM_ADDR, 1'b0, 1'b0, "rdto");
        for (int i = 0; i < TO; i++) begin
            run(1'b0, 1'b0, LW, L_MEM_RD, 1'b0, 1'b0, $sformatf("rdto_w%0d", i));
        end
        run(1'b0, 1'b0, LW, L_FAULT, 1'b0, 1'b1, "rdto");

        // sw data phase completing on the last allowed wait cycle.
        run(1'b1, 1'b1, SW, L_FAULT,    1'b0, 1'b1, "wrlim_rst");
        run(1'b0, 1'b1, SW, L_IDLE,     1'b0, 1'b0, "wrlim");
        run(1'b0, 1'b1, SW, L_FETCH,    1'b0, 1'b0, "wrlim");
        run(1'b0, 1'b1, SW, L_DECODE,   1'b0, 1'b0, "wrlim");
        run(1'b0, 1'b1, SW, L_MEM_ADDR, 1'b0, 1'b0, "wrlim");
        for (int i = 0; i < TO - 1; i++) begin
            run(1'b0, 1'b0, SW, L_MEM_WR, 1'b0, 1'b0, $sformatf("wrlim_w%0d", i));
        end
        run(1'b0, 1'b1, SW, L_MEM_WR, 1'b0, 1'b0, "wrlim_done");
        run(1'b0, 1'b1, SW, L_FETCH,  1'b0, 1'b0, "wrlim_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
